// File: rtl/phys_reg_release_queue.sv
// Commit-side release queue feeding the phys reg free list enqueue port.
// In-order FIFO of released tags; tag 0 is never freed.
package core_types_pkg;
  localparam int PHYS_REG_TAG_WIDTH = 6;
  typedef logic [PHYS_REG_TAG_WIDTH-1:0] phys_reg_tag_t;
endpackage

module phys_reg_release_queue
  import core_types_pkg::*;
#(
  parameter int RQ_DEPTH     = 4,
  parameter int LOG_RQ_DEPTH = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  output logic                    DUT_error,
  input  logic                    commit_valid,
  input  phys_reg_tag_t           commit_phys_reg_tag,
  output logic                    commit_ready,
  input  logic                    free_list_full,
  output logic                    enqueue_valid,
  output phys_reg_tag_t           enqueue_phys_reg_tag,
  output logic [LOG_RQ_DEPTH:0]   occupancy,
  output logic                    empty
);

  typedef logic [LOG_RQ_DEPTH:0] ptr_t;

  phys_reg_tag_t tag_q [RQ_DEPTH];
  ptr_t          head_q, head_d;
  ptr_t          tail_q, tail_d;
  logic          error_q, error_d;

  logic          full;
  logic          tag_nz;
  logic          accept;
  logic          drain;

  assign full = (head_q[LOG_RQ_DEPTH-1:0] == tail_q[LOG_RQ_DEPTH-1:0]) &&
                (head_q[LOG_RQ_DEPTH] != tail_q[LOG_RQ_DEPTH]);

  assign occupancy    = tail_q - head_q;
  assign empty        = (occupancy == '0);
  assign commit_ready = ~full;

  assign tag_nz = (commit_phys_reg_tag != '0);
  assign accept = commit_valid & ~full & tag_nz;
  assign drain  = ~empty & ~free_list_full;

  assign enqueue_valid        = drain;
  assign enqueue_phys_reg_tag = tag_q[head_q[LOG_RQ_DEPTH-1:0]];
  assign DUT_error            = error_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    error_d = commit_valid & full & tag_nz;
    if (accept) tail_d = tail_q + ptr_t'(1);
    if (drain)  head_d = head_q + ptr_t'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_q  <= '0;
      tail_q  <= '0;
      error_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      error_q <= error_d;
    end
  end

  // storage is cleared so the idle enqueue tag reads 0 out of reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < RQ_DEPTH; i++) tag_q[i] <= '0;
    end else if (accept) begin
      tag_q[tail_q[LOG_RQ_DEPTH-1:0]] <= commit_phys_reg_tag;
    end
  end

endmodule

// File: tb/tb_phys_reg_release_queue.sv
// Directed self-checking bench for phys_reg_release_queue.
// Inputs change 1ns after the rising edge; outputs sampled before the next edge.
module tb_phys_reg_release_queue;
  import core_types_pkg::*;

  logic          CLK = 1'b0;
  logic          RST;
  logic          DUT_error;
  logic          commit_valid;
  phys_reg_tag_t commit_phys_reg_tag;
  logic          commit_ready;
  logic          free_list_full;
  logic          enqueue_valid;
  phys_reg_tag_t enqueue_phys_reg_tag;
  logic [2:0]    occupancy;
  logic          empty;

  int checks = 0;
  int errors = 0;

  phys_reg_release_queue #(.RQ_DEPTH(4), .LOG_RQ_DEPTH(2)) dut (
    .CLK                  (CLK),
    .RST                  (RST),
    .DUT_error            (DUT_error),
    .commit_valid         (commit_valid),
    .commit_phys_reg_tag  (commit_phys_reg_tag),
    .commit_ready         (commit_ready),
    .free_list_full       (free_list_full),
    .enqueue_valid        (enqueue_valid),
    .enqueue_phys_reg_tag (enqueue_phys_reg_tag),
    .occupancy            (occupancy),
    .empty                (empty)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    commit_valid = 1'b0;
    commit_phys_reg_tag = '0;
    free_list_full = 1'b0;
    step();
    step();
    RST = 1'b0;
    #1;
    checks++;
    if (enqueue_valid !== 1'b0 || commit_ready !== 1'b1 ||
        occupancy !== 3'd0 || empty !== 1'b1 || DUT_error !== 1'b0 ||
        enqueue_phys_reg_tag !== 6'd0) begin
      errors++;
      $display("FAIL reset: ev=%b rdy=%b occ=%0d empty=%b err=%b tag=%0d want 0 1 0 1 0 0",
               enqueue_valid, commit_ready, occupancy, empty, DUT_error,
               enqueue_phys_reg_tag);
    end
  endtask

  task automatic test_single();
    free_list_full = 1'b0;
    commit_valid = 1'b1;
    commit_phys_reg_tag = 6'd40;
    #1;
    checks++;
    if (enqueue_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_nobypass: ev=%b want 0", enqueue_valid);
    end
    step();
    commit_valid = 1'b0;
    #1;
    checks++;
    if (enqueue_valid !== 1'b1 || enqueue_phys_reg_tag !== 6'd40 ||
        occupancy !== 3'd1) begin
      errors++;
      $display("FAIL single_emit: ev=%b tag=%0d occ=%0d want 1 40 1",
               enqueue_valid, enqueue_phys_reg_tag, occupancy);
    end
    step();
    checks++;
    if (enqueue_valid !== 1'b0 || occupancy !== 3'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL single_drained: ev=%b occ=%0d empty=%b want 0 0 1",
               enqueue_valid, occupancy, empty);
    end
  endtask

  task automatic test_tag_zero();
    commit_valid = 1'b1;
    commit_phys_reg_tag = 6'd0;
    step();
    commit_valid = 1'b0;
    #1;
    checks++;
    if (occupancy !== 3'd0 || enqueue_valid !== 1'b0 || DUT_error !== 1'b0) begin
      errors++;
      $display("FAIL tag_zero: occ=%0d ev=%b err=%b want 0 0 0",
               occupancy, enqueue_valid, DUT_error);
    end
  endtask

  task automatic test_overflow();
    free_list_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      commit_valid = 1'b1;
      commit_phys_reg_tag = 6'(33 + i);
      step();
    end
    commit_valid = 1'b0;
    #1;
    checks++;
    if (occupancy !== 3'd4 || commit_ready !== 1'b0 || enqueue_valid !== 1'b0) begin
      errors++;
      $display("FAIL fill: occ=%0d rdy=%b ev=%b want 4 0 0",
               occupancy, commit_ready, enqueue_valid);
    end
    commit_valid = 1'b1;
    commit_phys_reg_tag = 6'd37;
    step();
    commit_valid = 1'b0;
    #1;
    checks++;
    if (DUT_error !== 1'b1 || occupancy !== 3'd4) begin
      errors++;
      $display("FAIL overflow_err: err=%b occ=%0d want 1 4", DUT_error, occupancy);
    end
    step();
    checks++;
    if (DUT_error !== 1'b0) begin
      errors++;
      $display("FAIL overflow_err_pulse: err=%b want 0", DUT_error);
    end
    free_list_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (enqueue_valid !== 1'b1 || enqueue_phys_reg_tag !== 6'(33 + i)) begin
        errors++;
        $display("FAIL drain_%0d: ev=%b tag=%0d want 1 %0d",
                 i, enqueue_valid, enqueue_phys_reg_tag, 33 + i);
      end
      step();
    end
    checks++;
    if (enqueue_valid !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL drain_done: ev=%b empty=%b want 0 1 (37 must not appear)",
               enqueue_valid, empty);
    end
  endtask

  task automatic test_back_to_back();
    free_list_full = 1'b0;
    for (int i = 0; i < 10; i++) begin
      commit_valid = 1'b1;
      commit_phys_reg_tag = 6'(50 + i);
      #1;
      checks++;
      if (i == 0) begin
        if (enqueue_valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_first: ev=%b want 0", enqueue_valid);
        end
      end else if (enqueue_valid !== 1'b1 ||
                   enqueue_phys_reg_tag !== 6'(50 + i - 1) ||
                   occupancy !== 3'd1 || DUT_error !== 1'b0) begin
        errors++;
        $display("FAIL b2b_%0d: ev=%b tag=%0d occ=%0d err=%b want 1 %0d 1 0",
                 i, enqueue_valid, enqueue_phys_reg_tag, occupancy, DUT_error,
                 50 + i - 1);
      end
      step();
    end
    commit_valid = 1'b0;
    #1;
    checks++;
    if (enqueue_valid !== 1'b1 || enqueue_phys_reg_tag !== 6'd59) begin
      errors++;
      $display("FAIL b2b_last: ev=%b tag=%0d want 1 59",
               enqueue_valid, enqueue_phys_reg_tag);
    end
    step();
    checks++;
    if (empty !== 1'b1 || enqueue_valid !== 1'b0 || DUT_error !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: empty=%b ev=%b err=%b want 1 0 0",
               empty, enqueue_valid, DUT_error);
    end
  endtask

  task automatic test_toggle_and_reset();
    free_list_full = 1'b1;
    commit_valid = 1'b1;
    commit_phys_reg_tag = 6'd41;
    step();
    commit_phys_reg_tag = 6'd42;
    step();
    // accept + drain: occupancy must hold at 2
    commit_phys_reg_tag = 6'd43;
    free_list_full = 1'b0;
    #1;
    checks++;
    if (occupancy !== 3'd2 || enqueue_valid !== 1'b1 ||
        enqueue_phys_reg_tag !== 6'd41) begin
      errors++;
      $display("FAIL tog_41: occ=%0d ev=%b tag=%0d want 2 1 41",
               occupancy, enqueue_valid, enqueue_phys_reg_tag);
    end
    step();
    commit_phys_reg_tag = 6'd44;
    free_list_full = 1'b1;
    #1;
    checks++;
    if (occupancy !== 3'd2 || enqueue_valid !== 1'b0) begin
      errors++;
      $display("FAIL tog_hold: occ=%0d ev=%b want 2 0", occupancy, enqueue_valid);
    end
    step();
    commit_valid = 1'b0;
    free_list_full = 1'b0;
    #1;
    checks++;
    if (occupancy !== 3'd3 || enqueue_valid !== 1'b1 ||
        enqueue_phys_reg_tag !== 6'd42) begin
      errors++;
      $display("FAIL tog_42: occ=%0d ev=%b tag=%0d want 3 1 42",
               occupancy, enqueue_valid, enqueue_phys_reg_tag);
    end
    step();
    free_list_full = 1'b1;
    step();
    free_list_full = 1'b0;
    #1;
    checks++;
    if (occupancy !== 3'd2 || enqueue_valid !== 1'b1 ||
        enqueue_phys_reg_tag !== 6'd43) begin
      errors++;
      $display("FAIL tog_43: occ=%0d ev=%b tag=%0d want 2 1 43",
               occupancy, enqueue_valid, enqueue_phys_reg_tag);
    end
    step();
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if (empty !== 1'b1 || enqueue_valid !== 1'b0 || occupancy !== 3'd0) begin
      errors++;
      $display("FAIL async_rst: empty=%b ev=%b occ=%0d want 1 0 0",
               empty, enqueue_valid, occupancy);
    end
    step();
    RST = 1'b0;
    step();
    checks++;
    if (enqueue_valid !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL post_rst: ev=%b empty=%b want 0 1", enqueue_valid, empty);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tag_zero();
    test_overflow();
    test_back_to_back();
    test_toggle_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
